// File: rtl/exc_ctrl_if.sv
// Bundle between the commit stage, the epc register and the exception controller.
// master = pipeline / epc side, slave = exc_ctrl.
interface exc_ctrl_if #(
    parameter int NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq;
    logic               inst_valid;
    logic [31:0]        pc;
    logic               ri;
    logic               ovf;
    logic               syscall;
    logic               eret;
    logic               mtc0_we;
    logic [31:0]        mtc0_data;
    logic               epc_we;
    logic [31:0]        epc_pc;
    logic [31:0]        epc_in;
    logic [1:0]         pc_sel;
    logic [31:0]        target_pc;
    logic               flush;
    logic [31:0]        status;
    logic [31:0]        cause;

    modport master (
        output irq, inst_valid, pc, ri, ovf, syscall, eret, mtc0_we, mtc0_data, epc_in,
        input  epc_we, epc_pc, pc_sel, target_pc, flush, status, cause
    );

    modport slave (
        input  irq, inst_valid, pc, ri, ovf, syscall, eret, mtc0_we, mtc0_data, epc_in,
        output epc_we, epc_pc, pc_sel, target_pc, flush, status, cause
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller in front of the EPC register: trap decision, Status/Cause, eret.
// Optional macro EXC_CNT_EN adds a saturating trap counter output exc_cnt.
//
// state    | meaning
// S_RUN    | normal execution, evaluate commits for trap/eret
// S_TRAP   | one cycle: flush, redirect to EXC_VECTOR, EPC write if not nested
// S_RETURN | one cycle: flush, redirect to epc_in
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int          NUM_IRQ    = 4
) (
    input  logic         clk,
    input  logic         reset,
    exc_ctrl_if.slave    bus
`ifdef EXC_CNT_EN
    ,
    output logic [15:0]  exc_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_TRAP   = 2'b01,
        S_RETURN = 2'b10
    } state_t;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    state_t             state_q, state_d;
    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic [NUM_IRQ-1:0] ip_q, ip_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_pc_q, epc_pc_d;
    logic               epc_save_q, epc_save_d;

    logic               int_req;
    logic               take_trap;
    logic               take_ret;
    logic               is_int;
    logic [4:0]         trap_code;
    logic               unused_mtc0;

    assign unused_mtc0 = ^{bus.mtc0_data[31:8+NUM_IRQ], bus.mtc0_data[7:2]};

`ifdef EXC_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign exc_cnt = cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= '0;
            ip_q       <= '0;
            exc_code_q <= 5'd0;
            epc_pc_q   <= 32'd0;
            epc_save_q <= 1'b0;
`ifdef EXC_CNT_EN
            cnt_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_pc_q   <= epc_pc_d;
            epc_save_q <= epc_save_d;
`ifdef EXC_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_comb begin
        int_req    = ie_q & ~exl_q & (|(ip_q & im_q));
        take_trap  = 1'b0;
        take_ret   = 1'b0;
        is_int     = 1'b0;
        trap_code  = exc_code_q;

        // eret while already in the handler is a return; from user level it is illegal.
        if (state_q == S_RUN && bus.inst_valid) begin
            if (bus.ri) begin
                take_trap = 1'b1;
                trap_code = EXC_RI;
            end else if (bus.eret) begin
                if (exl_q) begin
                    take_ret = 1'b1;
                end else begin
                    take_trap = 1'b1;
                    trap_code = EXC_RI;
                end
            end else if (bus.ovf) begin
                take_trap = 1'b1;
                trap_code = EXC_OV;
            end else if (bus.syscall) begin
                take_trap = 1'b1;
                trap_code = EXC_SYS;
            end else if (int_req) begin
                take_trap = 1'b1;
                is_int    = 1'b1;
                trap_code = EXC_INT;
            end
        end

        state_d    = S_RUN;
        ie_d       = ie_q;
        exl_d      = exl_q;
        im_d       = im_q;
        ip_d       = bus.irq;
        exc_code_d = exc_code_q;
        epc_pc_d   = epc_pc_q;
        epc_save_d = epc_save_q;

        if (bus.mtc0_we) begin
            ie_d  = bus.mtc0_data[0];
            exl_d = bus.mtc0_data[1];
            im_d  = bus.mtc0_data[8 +: NUM_IRQ];
        end

        // Interrupted instruction completes, so the handler returns past it.
        if (take_trap) begin
            state_d    = S_TRAP;
            exl_d      = 1'b1;
            exc_code_d = trap_code;
            epc_save_d = ~exl_q;
            epc_pc_d   = is_int ? (bus.pc + 32'd4) : bus.pc;
        end else if (take_ret) begin
            state_d    = S_RETURN;
            exl_d      = 1'b0;
        end

`ifdef EXC_CNT_EN
        cnt_d = cnt_q;
        if (state_q == S_TRAP && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
`endif
    end

    always_comb begin
        bus.epc_we    = 1'b0;
        bus.epc_pc    = 32'd0;
        bus.pc_sel    = 2'b00;
        bus.target_pc = 32'd0;
        bus.flush     = 1'b0;

        case (state_q)
            S_TRAP: begin
                bus.epc_we    = epc_save_q;
                bus.epc_pc    = epc_pc_q;
                bus.pc_sel    = 2'b01;
                bus.target_pc = EXC_VECTOR;
                bus.flush     = 1'b1;
            end
            S_RETURN: begin
                bus.pc_sel    = 2'b10;
                bus.target_pc = bus.epc_in;
                bus.flush     = 1'b1;
            end
            default: ;
        endcase

        bus.status                = 32'd0;
        bus.status[0]             = ie_q;
        bus.status[1]             = exl_q;
        bus.status[8 +: NUM_IRQ]  = im_q;

        bus.cause                 = 32'd0;
        bus.cause[6:2]            = exc_code_q;
        bus.cause[8 +: NUM_IRQ]   = ip_q;
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios followed by random traffic, all checked against a trap model.
module tb_exc_ctrl;
    localparam int          NI  = 4;
    localparam logic [31:0] VEC = 32'h0000_0080;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exc_ctrl_if #(.NUM_IRQ(NI)) bus();

`ifdef EXC_CNT_EN
    logic [15:0] exc_cnt;
`endif

    exc_ctrl #(.EXC_VECTOR(VEC), .NUM_IRQ(NI)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus)
`ifdef EXC_CNT_EN
        ,
        .exc_cnt(exc_cnt)
`endif
    );

    // Model: phase 0 = running, 1 = trap cycle, 2 = return cycle.
    logic [1:0]    m_phase;
    logic          m_ie, m_exl, m_save;
    logic [NI-1:0] m_im, m_ip;
    logic [4:0]    m_code;
    logic [31:0]   m_epc;
    int            m_cnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] st, ca, tg;
        st = (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
        ca = (32'(m_ip) << 8) | (32'(m_code) << 2);
        tg = (m_phase == 2'd1) ? VEC : ((m_phase == 2'd2) ? bus.epc_in : 32'd0);
        chk("epc_we",    32'(bus.epc_we), 32'(m_phase == 2'd1 && m_save));
        chk("epc_pc",    bus.epc_pc, (m_phase == 2'd1) ? m_epc : 32'd0);
        chk("pc_sel",    32'(bus.pc_sel), 32'(m_phase));
        chk("target_pc", bus.target_pc, tg);
        chk("flush",     32'(bus.flush), 32'(m_phase != 2'd0));
        chk("status",    bus.status, st);
        chk("cause",     bus.cause, ca);
`ifdef EXC_CNT_EN
        chk("exc_cnt",   32'(exc_cnt), 32'(m_cnt));
`endif
    endtask

    // Advance one clock: evaluate the model on the current inputs, then compare after the edge.
    task automatic step();
        logic [1:0]    n_phase;
        logic          n_ie, n_exl, n_save, intr, ret, is_int;
        logic [NI-1:0] n_im, n_ip;
        logic [4:0]    n_code;
        logic [31:0]   n_epc;
        int            n_cnt, code;
        n_phase = 2'd0; n_ie = m_ie; n_exl = m_exl; n_save = m_save;
        n_im = m_im; n_ip = bus.irq; n_code = m_code; n_epc = m_epc; n_cnt = m_cnt;
        if (reset) begin
            n_ie = 0; n_exl = 0; n_save = 0; n_im = '0; n_ip = '0;
            n_code = 5'd0; n_epc = 32'd0; n_cnt = 0;
        end else begin
            intr   = m_ie && !m_exl && ((m_ip & m_im) != '0);
            code   = -1;
            ret    = 1'b0;
            is_int = 1'b0;
            if (m_phase == 2'd0 && bus.inst_valid) begin
                if (bus.ri || (bus.eret && !m_exl)) code = 10;
                else if (bus.eret)                  ret = 1'b1;
                else if (bus.ovf)                   code = 12;
                else if (bus.syscall)               code = 8;
                else if (intr) begin code = 0; is_int = 1'b1; end
            end
            if (m_phase == 2'd1) n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (bus.mtc0_we) begin
                n_ie  = bus.mtc0_data[0];
                n_exl = bus.mtc0_data[1];
                n_im  = bus.mtc0_data[8 +: NI];
            end
            if (code >= 0) begin
                n_phase = 2'd1;
                n_exl   = 1'b1;
                n_code  = 5'(code);
                n_save  = !m_exl;
                n_epc   = is_int ? bus.pc + 32'd4 : bus.pc;
            end else if (ret) begin
                n_phase = 2'd2;
                n_exl   = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_phase = n_phase; m_ie = n_ie; m_exl = n_exl; m_save = n_save;
        m_im = n_im; m_ip = n_ip; m_code = n_code; m_epc = n_epc; m_cnt = n_cnt;
        check_all();
    endtask

    task automatic clr();
        bus.inst_valid = 0; bus.ri = 0; bus.ovf = 0; bus.syscall = 0; bus.eret = 0;
        bus.mtc0_we = 0; bus.mtc0_data = 32'd0;
    endtask

    task automatic commit(input logic [31:0] pc_v);
        clr();
        bus.inst_valid = 1;
        bus.pc = pc_v;
    endtask

    task automatic do_eret();
        commit(32'h0000_0100);
        bus.eret = 1;
        step();
        clr();
        step();
    endtask

    initial begin
        m_phase = 0; m_ie = 0; m_exl = 0; m_save = 0; m_im = '0; m_ip = '0;
        m_code = 0; m_epc = 0; m_cnt = 0;
        reset = 1;
        clr();
        bus.irq = '0; bus.pc = 32'd0; bus.epc_in = 32'd0;
        step(); step();
        chk("rst_status", bus.status, 32'd0);
        chk("rst_cause", bus.cause, 32'd0);
        reset = 0;

        // Syscall trap then return.
        bus.mtc0_we = 1; bus.mtc0_data = 32'd0; step();
        commit(32'h0000_3010); bus.syscall = 1; step();
        chk("sys_epc_we", 32'(bus.epc_we), 32'd1);
        chk("sys_epc_pc", bus.epc_pc, 32'h0000_3010);
        chk("sys_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("sys_target", bus.target_pc, 32'h80);
        chk("sys_code", 32'(bus.cause[6:2]), 32'd8);
        chk("sys_exl", 32'(bus.status[1]), 32'd1);
        clr(); step();
        bus.epc_in = 32'h0000_3014;
        commit(32'h0000_0090); bus.eret = 1; step();
        chk("ret_pc_sel", 32'(bus.pc_sel), 32'd2);
        chk("ret_target", bus.target_pc, 32'h0000_3014);
        chk("ret_exl", 32'(bus.status[1]), 32'd0);
        clr(); step();

        // Interrupt; then eret with a pending irq must return before re-trapping.
        bus.mtc0_we = 1; bus.mtc0_data = 32'h0000_0301; step();
        clr(); bus.irq = 4'b0010; step();
        commit(32'h0000_4000); step();
        chk("int_code", 32'(bus.cause[6:2]), 32'd0);
        chk("int_epc_pc", bus.epc_pc, 32'h0000_4004);
        clr(); step();
        commit(32'h0000_0100); bus.eret = 1; step();
        chk("ret_irq_pc_sel", 32'(bus.pc_sel), 32'd2);
        commit(32'h0000_5000); step();
        chk("ret_ignored", 32'(bus.pc_sel), 32'd0);
        commit(32'h0000_5004); step();
        chk("int2_epc_pc", bus.epc_pc, 32'h0000_5008);
        clr(); bus.irq = '0; step();
        do_eret();

        // Same interrupt with IE=0: no trap.
        bus.mtc0_we = 1; bus.mtc0_data = 32'h0000_0300; step();
        clr(); bus.irq = 4'b0010; step();
        commit(32'h0000_4000); step();
        chk("noie_pc_sel", 32'(bus.pc_sel), 32'd0);
        clr(); bus.irq = '0; step();

        // Priority and nesting.
        commit(32'h0000_2000); bus.ri = 1; bus.ovf = 1; bus.syscall = 1; step();
        chk("prio_ri", 32'(bus.cause[6:2]), 32'd10);
        clr(); step();
        do_eret();
        commit(32'h0000_2004); bus.ovf = 1; bus.syscall = 1; step();
        chk("prio_ovf", 32'(bus.cause[6:2]), 32'd12);
        clr(); step();
        commit(32'h0000_0084); bus.ovf = 1; step();
        chk("nest_epc_we", 32'(bus.epc_we), 32'd0);
        chk("nest_exl", 32'(bus.status[1]), 32'd1);
        clr(); step();
        do_eret();

        // eret from user level is reserved.
        commit(32'h0000_2100); bus.eret = 1; step();
        chk("eret_ri", 32'(bus.cause[6:2]), 32'd10);
        clr(); step();
        do_eret();

        // Interrupt saved PC wraps.
        bus.mtc0_we = 1; bus.mtc0_data = 32'h0000_0301; step();
        clr(); bus.irq = 4'b0001; step();
        commit(32'hFFFF_FFFC); step();
        chk("wrap_epc_pc", bus.epc_pc, 32'h0000_0000);
        clr(); bus.irq = '0; step();
        do_eret();

        // Reset during the trap cycle.
        commit(32'h0000_6000); bus.syscall = 1; step();
        clr(); reset = 1; step();
        chk("rst_trap_sel", 32'(bus.pc_sel), 32'd0);
        chk("rst_trap_status", bus.status, 32'd0);
        reset = 0; step();

        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            bus.irq        = NI'($urandom);
            bus.inst_valid = ($urandom_range(0, 1) == 1);
            bus.pc         = $urandom & 32'hFFFF_FFFC;
            bus.ri         = ($urandom_range(0, 15) == 0);
            bus.ovf        = ($urandom_range(0, 11) == 0);
            bus.syscall    = ($urandom_range(0, 11) == 0);
            bus.eret       = ($urandom_range(0, 5) == 0);
            bus.mtc0_we    = ($urandom_range(0, 9) == 0);
            bus.mtc0_data  = $urandom;
            bus.epc_in     = $urandom & 32'hFFFF_FFFC;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt controller that sits directly upstream of the epc register.
- Collects synchronous exceptions (reserved instruction, overflow, syscall) and external interrupt lines at instruction commit.
- Decides when to trap: generates the EPC write pulse and the value to save, redirects the PC to the handler vector, and returns on eret.
- Holds the Status and Cause registers.

Parameters:
- EXC_VECTOR, 32'h0000_0080, handler entry address.
- NUM_IRQ, 4, number of external interrupt lines (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  NUM_IRQ  level interrupt requests.
- inst_valid  in  1  instruction at pc commits this cycle.
- pc  in  32  PC of the committing instruction.
- ri  in  1  reserved-instruction flag (qualified by inst_valid).
- ovf  in  1  ALU overflow flag (qualified by inst_valid).
- syscall  in  1  syscall flag (qualified by inst_valid).
- eret  in  1  eret flag (qualified by inst_valid).
- mtc0_we  in  1  write Status register.
- mtc0_data  in  32  Status write data.
- epc_we  out  1  one-cycle pulse: epc register loads epc_pc.
- epc_pc  out  32  value to save into EPC.
- epc_in  in  32  current EPC contents (from the epc register).
- pc_sel  out  2  00 sequential, 01 vector, 10 return to EPC.
- target_pc  out  32  EXC_VECTOR when pc_sel=01, epc_in when pc_sel=10, else 0.
- flush  out  1  kill younger in-flight instructions.
- status  out  32  bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM; others 0.
- cause  out  32  bits[6:2] ExcCode, bits[8+NUM_IRQ-1:8] IP; others 0.

Behaviour:
- Reset (synchronous, active-high):
  - state=RUN; status=0, cause=0.
  - epc_we=0, epc_pc=0, pc_sel=00, target_pc=0, flush=0.
  - Reset asserted in any state aborts it. No pending trap survives reset.
- IP field: registered copy of irq every cycle (1-cycle sampling latency).
- Interrupt request: int_req = IE & ~EXL & |(IP & IM).
- Trap priority (only when inst_valid=1 and state=RUN):
  1. ri → ExcCode 10.
  2. eret with EXL=0 → treated as RI, ExcCode 10.
  3. ovf → ExcCode 12.
  4. syscall → ExcCode 8.
  5. int_req → ExcCode 0.
- States:
  - RUN: on any trap condition → TRAP, else stay in RUN. eret with EXL=1 → RETURN.
  - TRAP (one cycle):
    - flush=1, pc_sel=01, target_pc=EXC_VECTOR.
    - epc_we=1 only if EXL was 0 at trap time; else epc_we=0 (EPC preserved).
    - ExcCode is written; EXL is set to 1.
    - Next state is RUN.
  - RETURN (one cycle): flush=1, pc_sel=10, target_pc=epc_in; EXL cleared; next state RUN.
- epc_pc:
  - Synchronous exception: pc.
  - Interrupt: pc+4 (committing instruction completes), mod 2^32; wrap from 32'hFFFF_FFFC gives 0.
- Registration: epc_pc and ExcCode are registered on the decision edge and are valid while epc_we=1.
- Trap latency: the trap cycle is the cycle after the committing instruction; the vector fetch follows.
- Non-RUN states: new trap/eret inputs are ignored while in TRAP or RETURN (pipeline is flushing).
- Simultaneous events:
  - mtc0_we in the same cycle as a trap decision: IE/IM take the written values, EXL is forced to 1.
  - mtc0_we in RUN: EXL takes mtc0_data[1].
  - eret with EXL=1 together with a pending irq: RETURN wins. The interrupt is taken no earlier than the first committing instruction after RETURN.
- Outputs other than status/cause are 0 in RUN.

Optional Feature:
- Macro: EXC_CNT_EN.
- When defined: adds output exc_cnt [15:0].
  - Increments on every TRAP cycle; saturates at 16'hFFFF.
  - Cleared by reset.
  - RETURN does not change it.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Syscall, reset released: status write 0 then inst_valid=1, syscall=1, pc=32'h0000_3010 → next cycle epc_we=1, epc_pc=32'h0000_3010, pc_sel=01, target_pc=32'h80, flush=1, cause[6:2]=8, status[1]=1.
- Interrupt: mtc0 0x0000_0301 (IE=1, IM[1:0]=11); irq=4'b0010; commit at pc=32'h0000_4000 → trap with ExcCode 0, epc_pc=32'h0000_4004. Same stimulus with IE=0 → no trap.
- Priority: ri=1, ovf=1, syscall=1 in one commit → ExcCode 10. With only ovf=1 and syscall=1 → ExcCode 12.
- Nested: while EXL=1, ovf at pc=32'h84 → TRAP with epc_we=0, ExcCode 12, EXL stays 1.
- Return: EXL=1, epc_in=32'h0000_3014, eret commit → pc_sel=10, target_pc=32'h0000_3014, flush=1, EXL=0. eret with EXL=0 → trap, ExcCode 10.
- Reset mid-TRAP: assert reset during the TRAP cycle → next edge all outputs 0, status=0. With EXC_CNT_EN, exc_cnt=0.
